// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE absorb datapath.
package shake_pkg;

    localparam int LANE_W = 64;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_e;

    // Rate in 64-bit lanes for each variant.
    localparam logic [4:0] RATE128 = 5'd21;
    localparam logic [4:0] RATE256 = 5'd17;

    localparam logic [7:0] PAD_DOMAIN = 8'h1F;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LEN,
        ABSORB,
        PERM,
        DONE
    } absorb_state_e;

    // Index of the last lane in a rate block for the given variant.
    function automatic logic [4:0] last_lane_idx(input shake_mode_e m);
        return (m == SHAKE256) ? (RATE256 - 5'd1) : (RATE128 - 5'd1);
    endfunction

endpackage

// File: rtl/absorb_ctrl_if.sv
// Message input stream: header word followed by 64-bit lanes, valid/ready handshake.
interface absorb_ctrl_if #(
    parameter int W = 64
) ();
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/shake_pad_lane.sv
// Applies SHAKE padding to a single rate lane (purely combinational).
module shake_pad_lane
    import shake_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] lane_in,
    input  logic [2:0]   rem_bytes,    // byte offset where the message ends in this lane
    input  logic         partial,      // message ends inside this lane
    input  logic         gen,          // message exhausted: lane is generated, not taken from input
    input  logic         pad_done_in,
    input  logic         last_lane,    // lane sits at index rate-1
    output logic [W-1:0] lane_out,
    output logic         pad_done_out,
    output logic         final_out
);

    // Domain byte placement, tail masking and the closing 0x80 on the last rate lane.
    always_comb begin
        lane_out     = lane_in;
        pad_done_out = pad_done_in;
        final_out    = 1'b0;

        if (gen) begin
            lane_out = '0;
            if (!pad_done_in) begin
                lane_out[7:0] = PAD_DOMAIN;
            end
            pad_done_out = 1'b1;
        end else if (partial) begin
            for (int b = 0; b < W / 8; b++) begin
                if (3'(b) >= rem_bytes) begin
                    lane_out[8*b +: 8] = 8'h00;
                end
            end
            lane_out[{rem_bytes, 3'b000} +: 8] = lane_out[{rem_bytes, 3'b000} +: 8] ^ PAD_DOMAIN;
            pad_done_out = 1'b1;
        end

        // A pad placed in this very lane also closes the block.
        if (last_lane && pad_done_out) begin
            lane_out[W-1 -: 8] = lane_out[W-1 -: 8] | PAD_FINAL;
            final_out          = 1'b1;
        end
    end

endmodule

// File: rtl/absorb_ctrl.sv
// Absorb-phase sequencer for the SHAKE core: length load, lane padding, permutation kicks.
module absorb_ctrl
    import shake_pkg::*;
#(
    parameter int LEN_W = 32,
    parameter int W     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    absorb_ctrl_if.slave     din_if,
    output logic             cnt_load,
    output logic [LEN_W-1:0] cnt_load_val,
    output logic             cnt_en,
    output logic [LEN_W-1:0] cnt_step,
    input  logic [LEN_W-1:0] cnt_value,
    input  logic             cnt_last_word,
    input  logic             cnt_zero,
    output logic [W-1:0]     blk_word,
    output logic             blk_valid,
    output logic [4:0]       blk_idx,
    output logic             perm_start,
    input  logic             perm_done,
    output logic             absorb_done
);

    absorb_state_e state_q, state_d;
    shake_mode_e   mode_q, mode_d;
    logic [4:0]    lane_idx_q, lane_idx_d;
    logic          pad_done_q, pad_done_d;
    logic          final_q, final_d;
    logic [W-1:0]  blk_word_q, blk_word_d;
    logic          blk_valid_q, blk_valid_d;
    logic [4:0]    blk_idx_q, blk_idx_d;
    logic          perm_start_q, perm_start_d;

    logic          din_ready;
    logic          last_lane;
    logic          partial;
    logic [W-1:0]  pad_lane;
    logic          pad_done_new;
    logic          pad_final;

    assign last_lane = (lane_idx_q == last_lane_idx(mode_q));
    // cnt_value == 64 is a full last lane; anything below it ends inside the lane.
    assign partial   = cnt_last_word && (cnt_value != LEN_W'(W));

    shake_pad_lane #(
        .W (W)
    ) u_pad (
        .lane_in      (din_if.din),
        .rem_bytes    (cnt_value[5:3]),
        .partial      (partial),
        .gen          (cnt_zero),
        .pad_done_in  (pad_done_q),
        .last_lane    (last_lane),
        .lane_out     (pad_lane),
        .pad_done_out (pad_done_new),
        .final_out    (pad_final)
    );

    // Next-state and handshake/counter outputs.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        lane_idx_d   = lane_idx_q;
        pad_done_d   = pad_done_q;
        final_d      = final_q;
        blk_word_d   = blk_word_q;
        blk_valid_d  = 1'b0;
        blk_idx_d    = blk_idx_q;
        perm_start_d = 1'b0;
        din_ready    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        absorb_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = shake_mode_e'(mode);
                    state_d = LOAD_LEN;
                end
            end
            LOAD_LEN: begin
                din_ready = 1'b1;
                if (din_if.din_valid) begin
                    cnt_load     = 1'b1;
                    // Lengths are whole bytes; the sub-byte bits are dropped.
                    cnt_load_val = {din_if.din[LEN_W-1:3], 3'b000};
                    lane_idx_d   = '0;
                    blk_idx_d    = '0;
                    pad_done_d   = 1'b0;
                    final_d      = 1'b0;
                    state_d      = ABSORB;
                end
            end
            ABSORB: begin
                din_ready = !cnt_zero;
                if (cnt_zero || din_if.din_valid) begin
                    cnt_en      = !cnt_zero;
                    blk_word_d  = pad_lane;
                    blk_valid_d = 1'b1;
                    blk_idx_d   = lane_idx_q;
                    lane_idx_d  = lane_idx_q + 5'd1;
                    pad_done_d  = pad_done_new;
                    if (last_lane) begin
                        final_d      = pad_final;
                        perm_start_d = 1'b1;
                        state_d      = PERM;
                    end
                end
            end
            PERM: begin
                if (perm_done) begin
                    if (final_q) begin
                        state_d = DONE;
                    end else begin
                        lane_idx_d = '0;
                        blk_idx_d  = '0;
                        state_d    = ABSORB;
                    end
                end
            end
            DONE: begin
                absorb_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and lane registers; reset abandons any message in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= SHAKE128;
            lane_idx_q   <= '0;
            pad_done_q   <= 1'b0;
            final_q      <= 1'b0;
            blk_word_q   <= '0;
            blk_valid_q  <= 1'b0;
            blk_idx_q    <= '0;
            perm_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            lane_idx_q   <= lane_idx_d;
            pad_done_q   <= pad_done_d;
            final_q      <= final_d;
            blk_word_q   <= blk_word_d;
            blk_valid_q  <= blk_valid_d;
            blk_idx_q    <= blk_idx_d;
            perm_start_q <= perm_start_d;
        end
    end

    assign din_if.din_ready = din_ready;
    assign cnt_step         = LEN_W'(W);
    assign blk_word         = blk_word_q;
    assign blk_valid        = blk_valid_q;
    assign blk_idx          = blk_idx_q;
    assign perm_start       = perm_start_q;

endmodule

// File: tb/tb_absorb_ctrl.sv
// Directed bench for absorb_ctrl with a length-counter model and a permutation responder.
module tb_absorb_ctrl;
    import shake_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        cnt_load, cnt_en, cnt_last_word, cnt_zero;
    logic [31:0] cnt_load_val, cnt_step, cnt_value;
    logic [63:0] blk_word;
    logic        blk_valid, perm_start, absorb_done;
    logic        perm_done = 1'b0;
    logic [4:0]  blk_idx;

    int errors = 0;
    int checks = 0;

    absorb_ctrl_if #(.W(64)) dif ();

    absorb_ctrl #(.LEN_W(32), .W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .din_if        (dif.slave),
        .cnt_load      (cnt_load),
        .cnt_load_val  (cnt_load_val),
        .cnt_en        (cnt_en),
        .cnt_step      (cnt_step),
        .cnt_value     (cnt_value),
        .cnt_last_word (cnt_last_word),
        .cnt_zero      (cnt_zero),
        .blk_word      (blk_word),
        .blk_valid     (blk_valid),
        .blk_idx       (blk_idx),
        .perm_start    (perm_start),
        .perm_done     (perm_done),
        .absorb_done   (absorb_done)
    );

    always #5 clk = ~clk;

    // External length counter.
    logic [31:0] cnt_r = 32'd0;
    always @(posedge clk) begin
        if (rst)           cnt_r <= 32'd0;
        else if (cnt_load) cnt_r <= cnt_load_val;
        else if (cnt_en)   cnt_r <= (cnt_r > 32'd64) ? cnt_r - 32'd64 : 32'd0;
    end
    assign cnt_value     = cnt_r;
    assign cnt_zero      = (cnt_r == 32'd0);
    assign cnt_last_word = (cnt_r <= 32'd64);

    // Permutation responder: perm_done a few cycles after each kick.
    int perm_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            perm_cnt  <= 0;
            perm_done <= 1'b0;
        end else begin
            perm_done <= 1'b0;
            if (perm_start) perm_cnt <= 3;
            else if (perm_cnt > 0) begin
                perm_cnt <= perm_cnt - 1;
                if (perm_cnt == 1) perm_done <= 1'b1;
            end
        end
    end

    // Output monitor.
    logic [63:0] cap_word [0:63];
    logic [4:0]  cap_idx  [0:63];
    int n_emit = 0, n_cnt_en = 0, n_perm = 0, n_done = 0, max_idx = 0;
    always @(negedge clk) begin
        if (blk_valid) begin
            if (n_emit < 64) begin
                cap_word[n_emit] = blk_word;
                cap_idx[n_emit]  = blk_idx;
            end
            if (int'(blk_idx) > max_idx) max_idx = int'(blk_idx);
            n_emit++;
        end
        if (cnt_en)      n_cnt_en++;
        if (perm_start)  n_perm++;
        if (absorb_done) n_done++;
    end

    logic [63:0] msg [0:31];

    task automatic clear_mon();
        n_emit = 0; n_cnt_en = 0; n_perm = 0; n_done = 0; max_idx = 0;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input bit gap, output bit ok);
        ok = 1'b0;
        if (gap) begin
            dif.din_valid = 1'b0;
            @(posedge clk); #1;
        end
        dif.din       = w;
        dif.din_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dif.din_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        dif.din_valid = 1'b0;
    endtask

    task automatic run_msg(input logic m, input int len, input bit gap, output bit ok);
        bit ok1;
        int nl;
        ok = 1'b1;
        clear_mon();
        do_start(m);
        send_word({32'h0, len[31:0]}, 1'b0, ok1);
        ok &= ok1;
        nl = (len + 63) / 64;
        for (int i = 0; i < nl; i++) begin
            send_word(msg[i], gap, ok1);
            ok &= ok1;
        end
        ok1 = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (absorb_done) begin
                ok1 = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        ok &= ok1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
        checks++; if ({dif.din_ready, cnt_load, cnt_en, blk_valid, perm_start, absorb_done} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000", {dif.din_ready, cnt_load, cnt_en, blk_valid, perm_start, absorb_done}); end
        checks++; if (blk_word !== 64'h0 || blk_idx !== 5'd0 || cnt_load_val !== 32'd0) begin
            errors++; $display("FAIL reset_data got=%h/%0d/%0d exp=0/0/0", blk_word, blk_idx, cnt_load_val); end
        checks++; if (cnt_step !== 32'd64) begin errors++; $display("FAIL reset_step got=%0d exp=64", cnt_step); end
        @(posedge clk); #1;
    endtask

    task automatic test_len0();
        bit ok;
        logic [63:0] e;
        run_msg(1'b0, 0, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL len0_timeout got=0 exp=1"); end
        checks++; if (n_emit !== 21) begin errors++; $display("FAIL len0_nlanes got=%0d exp=21", n_emit); end
        for (int i = 0; i < 21; i++) begin
            e = (i == 0) ? 64'h1F : (i == 20) ? 64'h8000_0000_0000_0000 : 64'h0;
            checks++; if (cap_word[i] !== e || cap_idx[i] !== 5'(i)) begin
                errors++; $display("FAIL len0_lane%0d got=%h@%0d exp=%h@%0d", i, cap_word[i], cap_idx[i], e, i); end
        end
        checks++; if (n_perm !== 1 || n_done !== 1 || n_cnt_en !== 0) begin
            errors++; $display("FAIL len0_counts got=%0d/%0d/%0d exp=1/1/0", n_perm, n_done, n_cnt_en); end
    endtask

    task automatic test_len24();
        bit ok;
        logic [63:0] e;
        msg[0] = 64'h1122_3344_55CC_BBAA;
        run_msg(1'b0, 24, 1'b0, ok);
        checks++; if (!ok || n_emit !== 21) begin errors++; $display("FAIL len24_run got=%0d/%0d exp=1/21", ok, n_emit); end
        for (int i = 0; i < 21; i++) begin
            e = (i == 0) ? 64'h0000_0000_1FCC_BBAA : (i == 20) ? 64'h8000_0000_0000_0000 : 64'h0;
            checks++; if (cap_word[i] !== e) begin errors++; $display("FAIL len24_lane%0d got=%h exp=%h", i, cap_word[i], e); end
        end
        checks++; if (n_cnt_en !== 1) begin errors++; $display("FAIL len24_cnt_en got=%0d exp=1", n_cnt_en); end
    endtask

    task automatic test_len64();
        bit ok;
        logic [63:0] e;
        msg[0] = 64'h0123_4567_89AB_CDEF;
        run_msg(1'b0, 64, 1'b0, ok);
        checks++; if (!ok || n_emit !== 21) begin errors++; $display("FAIL len64_run got=%0d/%0d exp=1/21", ok, n_emit); end
        for (int i = 0; i < 21; i++) begin
            e = (i == 0) ? 64'h0123_4567_89AB_CDEF : (i == 1) ? 64'h1F : (i == 20) ? 64'h8000_0000_0000_0000 : 64'h0;
            checks++; if (cap_word[i] !== e) begin errors++; $display("FAIL len64_lane%0d got=%h exp=%h", i, cap_word[i], e); end
        end
    endtask

    task automatic test_back_to_back_blocks();
        bit ok;
        logic [63:0] e;
        for (int i = 0; i < 21; i++) msg[i] = {32'hD000_0000 | 32'(i), 32'h1234_5678};
        run_msg(1'b0, 1344, 1'b0, ok);
        checks++; if (!ok || n_emit !== 42) begin errors++; $display("FAIL b2b_run got=%0d/%0d exp=1/42", ok, n_emit); end
        for (int i = 0; i < 42; i++) begin
            if (i < 21)       e = {32'hD000_0000 | 32'(i), 32'h1234_5678};
            else if (i == 21) e = 64'h1F;
            else if (i == 41) e = 64'h8000_0000_0000_0000;
            else              e = 64'h0;
            checks++; if (cap_word[i] !== e || cap_idx[i] !== 5'(i % 21)) begin
                errors++; $display("FAIL b2b_lane%0d got=%h@%0d exp=%h@%0d", i, cap_word[i], cap_idx[i], e, i % 21); end
        end
        checks++; if (n_perm !== 2 || n_cnt_en !== 21 || n_done !== 1) begin
            errors++; $display("FAIL b2b_counts got=%0d/%0d/%0d exp=2/21/1", n_perm, n_cnt_en, n_done); end
    endtask

    task automatic test_shake256_9f();
        bit ok;
        logic [63:0] e;
        for (int i = 0; i < 17; i++) msg[i] = (i == 16) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'hC0DE_0000 | 32'(i), 32'hCAFE_F00D};
        run_msg(1'b1, 1080, 1'b0, ok);
        checks++; if (!ok || n_emit !== 17) begin errors++; $display("FAIL s256_run got=%0d/%0d exp=1/17", ok, n_emit); end
        for (int i = 0; i < 17; i++) begin
            e = (i == 16) ? 64'h9FFF_FFFF_FFFF_FFFF : {32'hC0DE_0000 | 32'(i), 32'hCAFE_F00D};
            checks++; if (cap_word[i] !== e) begin errors++; $display("FAIL s256_lane%0d got=%h exp=%h", i, cap_word[i], e); end
        end
        checks++; if (max_idx !== 16 || n_perm !== 1) begin
            errors++; $display("FAIL s256_idx got=%0d/%0d exp=16/1", max_idx, n_perm); end
    endtask

    task automatic test_stall_and_reset();
        bit ok;
        for (int i = 0; i < 4; i++) msg[i] = 64'hABCD_0000_0000_0000 | 64'(i);
        clear_mon();
        do_start(1'b0);
        send_word({32'h0, 32'd256}, 1'b0, ok);
        send_word(msg[0], 1'b1, ok);
        send_word(msg[1], 1'b1, ok);
        dif.din       = msg[2];
        dif.din_valid = 1'b1;
        rst           = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        dif.din_valid = 1'b0;
        @(negedge clk);
        checks++; if (n_emit !== 2) begin errors++; $display("FAIL rstmid_nlanes got=%0d exp=2", n_emit); end
        checks++; if (cap_idx[0] !== 5'd0 || cap_idx[1] !== 5'd1 || cap_word[0] !== msg[0] || cap_word[1] !== msg[1]) begin
            errors++; $display("FAIL rstmid_lanes got=%0d:%h %0d:%h exp=0:%h 1:%h", cap_idx[0], cap_word[0], cap_idx[1], cap_word[1], msg[0], msg[1]); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.state_q, IDLE); end
        checks++; if ({blk_valid, perm_start, absorb_done, cnt_load, cnt_en, dif.din_ready} !== 6'b0 || blk_word !== 64'h0 || blk_idx !== 5'd0) begin
            errors++; $display("FAIL rstmid_outputs got=%b/%h/%0d exp=000000/0/0", {blk_valid, perm_start, absorb_done, cnt_load, cnt_en, dif.din_ready}, blk_word, blk_idx); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (n_perm !== 0 || n_emit !== 2) begin errors++; $display("FAIL rstmid_quiet got=%0d/%0d exp=0/2", n_perm, n_emit); end
        run_msg(1'b1, 0, 1'b0, ok);
        checks++; if (!ok || n_emit !== 17 || n_done !== 1 || n_perm !== 1) begin
            errors++; $display("FAIL rstmid_restart got=%0d/%0d/%0d/%0d exp=1/17/1/1", ok, n_emit, n_done, n_perm); end
        checks++; if (cap_word[0] !== 64'h1F || cap_word[16] !== 64'h8000_0000_0000_0000) begin
            errors++; $display("FAIL rstmid_restart_pad got=%h/%h exp=1f/8000000000000000", cap_word[0], cap_word[16]); end
    endtask

    task automatic test_stall_gaps();
        bit ok;
        logic [63:0] e;
        for (int i = 0; i < 4; i++) msg[i] = 64'h5555_0000_0000_0000 | 64'(i * 3);
        run_msg(1'b0, 256, 1'b1, ok);
        checks++; if (!ok || n_emit !== 21 || n_cnt_en !== 4) begin
            errors++; $display("FAIL gaps_run got=%0d/%0d/%0d exp=1/21/4", ok, n_emit, n_cnt_en); end
        for (int i = 0; i < 5; i++) begin
            e = (i < 4) ? (64'h5555_0000_0000_0000 | 64'(i * 3)) : 64'h1F;
            checks++; if (cap_word[i] !== e || cap_idx[i] !== 5'(i)) begin
                errors++; $display("FAIL gaps_lane%0d got=%h@%0d exp=%h@%0d", i, cap_word[i], cap_idx[i], e, i); end
        end
    endtask

    initial begin
        dif.din       = '0;
        dif.din_valid = 1'b0;
        test_reset();
        test_len0();
        test_len24();
        test_len64();
        test_back_to_back_blocks();
        test_shake256_9f();
        test_stall_gaps();
        test_stall_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
